// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes, funct codes, ULA codes.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BEQ, ADDIEX, ADDIWB, JUMP
    } estado_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} alu_op_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_SLT = 3'b111;

endpackage

// File: rtl/ula_decodificador.sv
// Purpose: maps the FSM's ALU request plus funct onto the ULA operation code and carry-in.
// Latency: purely combinational, zero cycles.
// Backpressure: none; funct_ok flags funct codes the ULA does not implement.
module ula_decodificador
    import mips_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [5:0]  funct,
    output logic [2:0]  ula_controle,
    output logic        ula_cin,
    output logic        funct_ok
);

    always_comb begin
        ula_controle = ULA_ADD;
        ula_cin      = 1'b0;
        funct_ok     = 1'b1;
        case (alu_op)
            ALU_SUB: begin
                ula_controle = ULA_SUB;
                ula_cin      = 1'b1;
            end
            ALU_FUNCT: begin
                case (funct)
                    FN_ADD: ula_controle = ULA_ADD;
                    FN_SUB: begin
                        ula_controle = ULA_SUB;
                        ula_cin      = 1'b1;
                    end
                    FN_AND: ula_controle = ULA_AND;
                    FN_OR:  ula_controle = ULA_OR;
                    // slt is a subtraction underneath, so it needs the +1 as well
                    FN_SLT: begin
                        ula_controle = ULA_SLT;
                        ula_cin      = 1'b1;
                    end
                    default: funct_ok = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Purpose: multicycle MIPS main control FSM driving datapath enables, muxes and the ULA.
// Latency: lw 5 cycles; sw, R-type, addi 4; beq, j 3; unsupported opcode 2.
// Backpressure: none; one instruction in flight, rst aborts it and forces safe outputs.
module controle_multiciclo
    import mips_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int FUNCT_W = 6,
    parameter int CTRL_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    output logic [CTRL_W-1:0]  ULAcontrole,
    output logic               ula_cin,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic               illegal_op
);

    estado_t estado;
    logic    eh_lw;
    alu_op_t alu_op;
    logic    funct_ok;

    ula_decodificador u_ula_dec (
        .alu_op       (alu_op),
        .funct        (funct),
        .ula_controle (ULAcontrole),
        .ula_cin      (ula_cin),
        .funct_ok     (funct_ok)
    );

    // lw/sw is captured in DECODE so MEMADR never looks at the opcode again
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= FETCH;
            eh_lw  <= 1'b0;
        end else begin
            case (estado)
                FETCH:  estado <= DECODE;
                DECODE: begin
                    eh_lw <= (opcode == OP_LW);
                    case (opcode)
                        OP_LW, OP_SW: estado <= MEMADR;
                        OP_R:         estado <= EXEC;
                        OP_BEQ:       estado <= BEQ;
                        OP_ADDI:      estado <= ADDIEX;
                        OP_J:         estado <= JUMP;
                        default:      estado <= FETCH;
                    endcase
                end
                MEMADR: estado <= eh_lw ? MEMRD : MEMWR;
                MEMRD:  estado <= MEMWB;
                MEMWB:  estado <= FETCH;
                MEMWR:  estado <= FETCH;
                EXEC:   estado <= funct_ok ? ALUWB : FETCH;
                ALUWB:  estado <= FETCH;
                BEQ:    estado <= FETCH;
                ADDIEX: estado <= ADDIWB;
                ADDIWB: estado <= FETCH;
                JUMP:   estado <= FETCH;
                default: estado <= FETCH;
            endcase
        end
    end

    // Outputs follow the state register; rst overrides them so nothing is written while held
    always_comb begin
        alu_op     = ALU_ADD;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        illegal_op = 1'b0;
        if (!rst) begin
            case (estado)
                FETCH: begin
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_en     = 1'b1;
                end
                DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
                end
                MEMADR, ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: iord = 1'b1;
                MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_FUNCT;
                    illegal_op = !funct_ok;
                end
                ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                ADDIWB: reg_write = 1'b1;
                BEQ: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = 2'b01;
                    pc_en     = zero;
                end
                JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed and random instructions against a per-cycle instruction table.
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] ULAcontrole;
    logic       ula_cin, pc_en, iord, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0] ctrl;
        logic       cin;
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       illegal;
    } obs_t;

    obs_t obs;

    controle_multiciclo dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .ULAcontrole (ULAcontrole),
        .ula_cin     (ula_cin),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    always_comb obs = {ULAcontrole, ula_cin, pc_en, iord, mem_write, ir_write, reg_write,
                       reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, illegal_op};

    function automatic obs_t vetor_reset();
        obs_t e;
        e = '0;
        e.ctrl = 3'b010;
        return e;
    endfunction

    function automatic logic funct_valido(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic int ciclos(input logic [5:0] opc, input logic [5:0] fn);
        case (opc)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return funct_valido(fn) ? 4 : 3;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // Expected outputs for cycle k (0 = fetch) of an instruction, straight from the instruction table
    function automatic obs_t esperado(input logic [5:0] opc, input logic [5:0] fn,
                                      input int k, input logic z);
        obs_t e;
        e = vetor_reset();
        if (k == 0) begin
            e.ir_write = 1'b1; e.alu_src_b = 2'b01; e.pc_en = 1'b1;
        end else if (k == 1) begin
            e.alu_src_b = 2'b11;
            e.illegal = ciclos(opc, 6'b100000) == 2;
        end else begin
            case (opc)
                6'b100011, 6'b101011: begin
                    if (k == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
                    else if (opc == 6'b101011) begin e.iord = 1'b1; e.mem_write = 1'b1; end
                    else if (k == 3) e.iord = 1'b1;
                    else begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
                end
                6'b000000: begin
                    if (k == 2) begin
                        e.alu_src_a = 1'b1;
                        case (fn)
                            6'b100000: e.ctrl = 3'b010;
                            6'b100010: begin e.ctrl = 3'b110; e.cin = 1'b1; end
                            6'b100100: e.ctrl = 3'b000;
                            6'b100101: e.ctrl = 3'b001;
                            6'b101010: begin e.ctrl = 3'b111; e.cin = 1'b1; end
                            default:   e.illegal = 1'b1;
                        endcase
                    end else begin
                        e.reg_dst = 1'b1; e.reg_write = 1'b1;
                    end
                end
                6'b001000: begin
                    if (k == 2) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
                    else e.reg_write = 1'b1;
                end
                6'b000100: begin
                    e.alu_src_a = 1'b1; e.ctrl = 3'b110; e.cin = 1'b1;
                    e.pc_src = 2'b01; e.pc_en = z;
                end
                6'b000010: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic checa(input string tag, input obs_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH; opcode/funct are scrambled outside DECODE/EXEC.
    // zmode: 0/1 fixed zero, 2 random. abort_k >= 0 asserts rst in that cycle.
    task automatic instr(input string nome, input logic [5:0] opc, input logic [5:0] fn,
                         input int zmode, input int abort_k);
        int n;
        n = ciclos(opc, fn);
        for (int k = 0; k < n; k++) begin
            opcode = (k == 1) ? opc : 6'($urandom);
            funct  = (k == 2) ? fn  : 6'($urandom);
            zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            if (k == abort_k) rst = 1'b1;
            @(negedge clk);
            if (k == abort_k)
                checa($sformatf("%s_rst_c%0d", nome, k), vetor_reset());
            else
                checa($sformatf("%s_c%0d", nome, k), esperado(opc, fn, k, zero));
            @(posedge clk);
            #1;
            if (k == abort_k) begin
                rst = 1'b0;
                break;
            end
        end
    endtask

    logic [5:0] opcs [8];
    logic [5:0] fns  [6];

    initial begin
        rst = 1'b1; opcode = 6'b100011; funct = 6'b100000; zero = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checa("reset", vetor_reset());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        instr("lw",        6'b100011, 6'b000000, 2, -1);
        instr("r_sub",     6'b000000, 6'b100010, 2, -1);
        instr("beq_z1",    6'b000100, 6'b000000, 1, -1);
        instr("beq_z0",    6'b000100, 6'b000000, 0, -1);
        instr("bad_opc",   6'b111111, 6'b000000, 2, -1);
        instr("bad_funct", 6'b000000, 6'b000111, 2, -1);
        instr("sw_abort",  6'b101011, 6'b000000, 2, 3);
        instr("j",         6'b000010, 6'b000000, 2, -1);
        instr("r_add",     6'b000000, 6'b100000, 2, -1);
        instr("r_and",     6'b000000, 6'b100100, 2, -1);
        instr("r_or",      6'b000000, 6'b100101, 2, -1);
        instr("r_slt",     6'b000000, 6'b101010, 2, -1);
        instr("addi",      6'b001000, 6'b000000, 2, -1);
        instr("sw",        6'b101011, 6'b000000, 2, -1);

        opcs = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                 6'b001000, 6'b000010, 6'b000000, 6'b111111};
        fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int i = 0; i < 200; i++) begin
            logic [5:0] o, f;
            o = ($urandom_range(9, 0) == 0) ? 6'($urandom) : opcs[$urandom_range(7, 0)];
            f = ($urandom_range(7, 0) == 0) ? 6'($urandom) : fns[$urandom_range(4, 0)];
            instr($sformatf("rnd%0d", i), o, f, 2, ($urandom_range(19, 0) == 0) ? 2 : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
